aes128_enc_ctrl: RTL and testbench

Iterative AES-128 encryption controller that sequences one cipher round per clock around the team's round datapath: SubBytes, ShiftRows, MixColumns, the addroundkey combinational stage, and an on-the-fly key schedule.
Accepts a plaintext/key pair on a start handshake and runs the initial key addition, NUM_ROUNDS-1 full rounds and one final round without MixColumns.
Returns the ciphertext with a one-cycle done pulse.
Sits between the host/bus interface and the combinational round logic.

---
 rtl/aes128_enc_ctrl.sv | 168 ++++++++++++++++
 tb/tb_aes128_enc_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_enc_ctrl.sv
// Iterative AES-128 encryption controller: one cipher round per clock.
// Accepts a plaintext/key pair on start, runs the initial key addition,
// NUM_ROUNDS-1 full rounds and a final round without MixColumns, then
// presents the ciphertext with a one-cycle done pulse.
module aes128_enc_ctrl #(
    parameter int unsigned NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    output logic         busy,
    output logic         done,
    output logic [127:0] ciphertext,
    output logic [3:0]   round_idx
);

    // Forward S-box, entry 0x00 in the top byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [3:0] LAST_FULL = 4'(NUM_ROUNDS - 1);

    typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

    state_t         state, state_nxt;
    logic           accept;
    logic [127:0]   state_reg;
    logic [127:0]   key_reg;
    logic [127:0]   next_key;
    logic [31:0]    rot_w;
    logic [31:0]    t_word;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        // Entry b sits at bit offset 8*(255-b) = {~b, 3'b000}.
        return SBOX_TABLE[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] v;
        case (r)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    // SubBytes followed by ShiftRows; byte (row r, col c) lives at index 4c+r.
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned rw = 0; rw < 4; rw++) begin
                r[7'(127 - 8 * (4 * c + rw)) -: 8] =
                    sbox(s[7'(127 - 8 * (4 * ((c + rw) % 4) + rw)) -: 8]);
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            {a0, a1, a2, a3} = s[7'(127 - 32 * c) -: 32];
            r[7'(127 - 32 * c) -: 32] = {
                xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
            };
        end
        return r;
    endfunction

    assign busy = (state != IDLE);

    // On-the-fly key schedule: round key for the round being executed.
    always_comb begin
        rot_w    = {key_reg[23:0], key_reg[31:24]};
        t_word   = {sbox(rot_w[31:24]), sbox(rot_w[23:16]),
                    sbox(rot_w[15:8]),  sbox(rot_w[7:0])} ^ {rcon(round_idx), 24'h0};
        next_key[127:96] = key_reg[127:96] ^ t_word;
        next_key[95:64]  = key_reg[95:64]  ^ next_key[127:96];
        next_key[63:32]  = key_reg[63:32]  ^ next_key[95:64];
        next_key[31:0]   = key_reg[31:0]   ^ next_key[63:32];
    end

    // Control state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic and start acceptance.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = (NUM_ROUNDS == 1) ? FINAL : ROUND;
                end
            end
            ROUND:   if (round_idx == LAST_FULL) state_nxt = FINAL;
            FINAL:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Round datapath, key register, round counter and result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= '0;
            key_reg    <= '0;
            round_idx  <= '0;
            ciphertext <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state_reg <= plaintext ^ key;
                        key_reg   <= key;
                        round_idx <= 4'd1;
                    end
                end
                ROUND: begin
                    state_reg <= mix_columns(sub_shift(state_reg)) ^ next_key;
                    key_reg   <= next_key;
                    round_idx <= round_idx + 4'd1;
                end
                FINAL: begin
                    ciphertext <= sub_shift(state_reg) ^ next_key;
                    done       <= 1'b1;
                    round_idx  <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes128_enc_ctrl.sv
// Self-checking bench for aes128_enc_ctrl: directed scenarios plus random
// blocks, checked against an arithmetic AES-128 reference model.
module tb_aes128_enc_ctrl;

    localparam logic [127:0] V1_PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] V1_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] V1_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] V2_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] K1_ZERO = 128'h62636363626363636263636362636363;
    localparam logic [127:0] R1_ZERO = 128'h01000000010000000100000001000000;

    logic         clk = 1'b0;
    logic         rst;
    logic         start, start1;
    logic [127:0] plaintext, key, pt1, key1;
    logic         busy, done, busy1, done1;
    logic [127:0] ciphertext, ct1;
    logic [3:0]   round_idx, ridx1;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] sb_ref [256];

    always #5 clk = ~clk;

    aes128_enc_ctrl #(.NUM_ROUNDS(10)) dut (
        .clk(clk), .rst(rst), .start(start), .plaintext(plaintext), .key(key),
        .busy(busy), .done(done), .ciphertext(ciphertext), .round_idx(round_idx)
    );

    aes128_enc_ctrl #(.NUM_ROUNDS(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .plaintext(pt1), .key(key1),
        .busy(busy1), .done(done1), .ciphertext(ct1), .round_idx(ridx1)
    );

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    // Multiplicative inverse (x^254) followed by the affine transform.
    function automatic logic [7:0] sbox_entry(input int x);
        logic [7:0] inv, b;
        inv = 8'h01;
        b   = 8'(x);
        for (int e = 0; e < 254; e++) inv = gmul(inv, b);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] gb(input logic [127:0] v, input int i);
        return v[7'(127 - 8 * i) -: 8];
    endfunction

    task automatic aes_ref(input logic [127:0] pt, input logic [127:0] k0, input int nr,
                           output logic [127:0] ct, output logic [127:0] k1);
        logic [7:0] s [16];
        logic [7:0] k [16];
        logic [7:0] t [16];
        logic [7:0] tmp [4];
        logic [7:0] rc, a0, a1, a2, a3;
        for (int i = 0; i < 16; i++) begin
            k[i] = gb(k0, i);
            s[i] = gb(pt, i) ^ k[i];
        end
        rc = 8'h01;
        k1 = '0;
        for (int r = 1; r <= nr; r++) begin
            tmp[0] = sb_ref[k[13]] ^ rc;
            tmp[1] = sb_ref[k[14]];
            tmp[2] = sb_ref[k[15]];
            tmp[3] = sb_ref[k[12]];
            for (int j = 0; j < 4; j++)  k[j] = k[j] ^ tmp[j];
            for (int j = 4; j < 16; j++) k[j] = k[j] ^ k[j-4];
            rc = gmul(rc, 8'h02);
            if (r == 1) for (int i = 0; i < 16; i++) k1 = {k1[119:0], k[i]};
            for (int i = 0; i < 16; i++)
                t[i] = sb_ref[s[4 * ((i / 4 + i % 4) % 4) + i % 4]];
            if (r < nr) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end else begin
                for (int i = 0; i < 16; i++) s[i] = t[i];
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[i];
        end
        ct = '0;
        for (int i = 0; i < 16; i++) ct = {ct[119:0], s[i]};
    endtask

    // ---------------- helpers ----------------
    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int limit, output int cycles);
        cycles = 0;
        while (!done && cycles < limit) begin
            tick();
            cycles++;
        end
    endtask

    task automatic run_block(input logic [127:0] pt, input logic [127:0] k, input string tag);
        logic [127:0] exp_ct, k1;
        int n;
        aes_ref(pt, k, 10, exp_ct, k1);
        plaintext = pt; key = k; start = 1'b1;
        tick();
        start = 1'b0; plaintext = rand128(); key = rand128();
        wait_done(20, n);
        check({tag, "_latency"}, 128'(n), 128'd10);
        check({tag, "_ct"}, ciphertext, exp_ct);
        tick();
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [127:0] exp_ct, k1, rv_pt, rv_key, captured;
        int n, dones, first;
        bit stable;

        rst = 1'b1; start = 1'b0; start1 = 1'b0;
        plaintext = '0; key = '0; pt1 = '0; key1 = '0;
        for (int x = 0; x < 256; x++) sb_ref[x] = sbox_entry(x);

        #2;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_ct", ciphertext, '0);
        check("rst_round_idx", round_idx, 4'd0);
        check("rst_busy1", busy1, 1'b0);
        #8 rst = 1'b0;
        tick();

        // Known-answer vector 1 with per-cycle busy/round_idx tracking.
        plaintext = V1_PT; key = V1_KEY; start = 1'b1;
        tick();
        start = 1'b0; plaintext = rand128(); key = rand128();
        for (int k = 1; k <= 10; k++) begin
            check("t1_busy", busy, 1'b1);
            check("t1_round_idx", round_idx, 128'(k));
            check("t1_done_low", done, 1'b0);
            tick();
        end
        check("t1_done", done, 1'b1);
        check("t1_busy_end", busy, 1'b0);
        check("t1_round_idx_end", round_idx, 4'd0);
        check("t1_ct", ciphertext, V1_CT);
        tick();
        check("t1_done_pulse", done, 1'b0);
        check("t1_ct_hold", ciphertext, V1_CT);

        // Vector 2: all zero, including the first round key.
        aes_ref('0, '0, 10, exp_ct, k1);
        plaintext = '0; key = '0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("t2_key_reg_r1", dut.key_reg, K1_ZERO);
        check("t2_key_reg_model", dut.key_reg, k1);
        wait_done(20, n);
        check("t2_latency", 128'(n), 128'd9);
        check("t2_ct", ciphertext, V2_CT);
        tick();

        // Back-to-back with start held high.
        plaintext = V1_PT; key = V1_KEY; start = 1'b1;
        tick();
        plaintext = '0; key = '0;
        wait_done(20, n);
        check("t3_latency_a", 128'(n), 128'd10);
        check("t3_ct_a", ciphertext, V1_CT);
        tick();
        plaintext = rand128(); key = rand128();
        n = 0; stable = 1'b1;
        while (!done && n < 20) begin
            if (ciphertext !== V1_CT) stable = 1'b0;
            tick();
            n++;
        end
        start = 1'b0;
        check("t3_ct_a_stable", 128'(stable), 128'd1);
        check("t3_latency_b", 128'(n), 128'd10);
        check("t3_ct_b", ciphertext, V2_CT);
        tick();

        // Start while busy is ignored.
        plaintext = V1_PT; key = V1_KEY; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        plaintext = '0; key = '0; start = 1'b1;
        tick();
        start = 1'b0;
        check("t4_busy", busy, 1'b1);
        check("t4_round_idx", round_idx, 4'd5);
        n = 4; dones = 0; first = 0; captured = '0;
        while (n < 24) begin
            tick();
            n++;
            if (done) begin
                dones++;
                if (first == 0) begin
                    first = n;
                    captured = ciphertext;
                end
            end
        end
        check("t4_done_count", 128'(dones), 128'd1);
        check("t4_done_cycle", 128'(first), 128'd10);
        check("t4_ct", captured, V1_CT);

        // Asynchronous reset mid-block.
        rv_pt = rand128(); rv_key = rand128();
        plaintext = rv_pt; key = rv_key; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        #3 rst = 1'b1;
        #1;
        check("t5_busy", busy, 1'b0);
        check("t5_done", done, 1'b0);
        check("t5_ct", ciphertext, '0);
        check("t5_round_idx", round_idx, 4'd0);
        check("t5_key_reg", dut.key_reg, '0);
        #2 rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done) dones++;
        end
        check("t5_no_done", 128'(dones), 128'd0);
        check("t5_idle", busy, 1'b0);
        run_block(rv_pt, rv_key, "t5_restart");

        // Random blocks against the model.
        for (int i = 0; i < 6; i++) run_block(rand128(), rand128(), "rand");

        // Single-round instance.
        pt1 = '0; key1 = '0; start1 = 1'b1;
        tick();
        start1 = 1'b0; pt1 = rand128(); key1 = rand128();
        check("t6_busy", busy1, 1'b1);
        check("t6_done_low", done1, 1'b0);
        check("t6_round_idx", ridx1, 4'd1);
        tick();
        aes_ref('0, '0, 1, exp_ct, k1);
        check("t6_done", done1, 1'b1);
        check("t6_busy_end", busy1, 1'b0);
        check("t6_ct_model", ct1, exp_ct);
        check("t6_ct_const", ct1, R1_ZERO);
        tick();
        check("t6_done_pulse", done1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            rv_pt = rand128(); rv_key = rand128();
            aes_ref(rv_pt, rv_key, 1, exp_ct, k1);
            pt1 = rv_pt; key1 = rv_key; start1 = 1'b1;
            tick();
            start1 = 1'b0; pt1 = rand128(); key1 = rand128();
            tick();
            check("t6_rand_done", done1, 1'b1);
            check("t6_rand_ct", ct1, exp_ct);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
